// File: rtl/bus_pkg.sv
// Shared bus types for the data-RAM arbiter: FSM states, width constants and
// the request payload struct used for master inputs and the transaction register.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_STRB_W = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wstrb;
    logic [BUS_STRB_W-1:0] rstrb;
  } bus_req_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie goes
// to the master that was not granted last.
module ram_arb_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of the shared data RAM. One
// transaction at a time: sample in IDLE, drive RAM in ACCESS, ack in RESP.
module ram_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W,
  parameter int unsigned STRB_W = BUS_STRB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic [STRB_W-1:0] m0_rstrb,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic [STRB_W-1:0] m1_rstrb,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_read_addr,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [DATA_W-1:0] ram_write_data,
  output logic [STRB_W-1:0] ram_write_strb,
  output logic [STRB_W-1:0] ram_read_strb,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              busy
);

  arb_state_t state;
  bus_req_t   txn;
  bus_req_t   m0_in;
  bus_req_t   m1_in;
  bus_req_t   sel_in;
  logic       last_grant;
  logic       pick_valid;
  logic       pick_winner;

  assign m0_in  = '{we: m0_we, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb, rstrb: m0_rstrb};
  assign m1_in  = '{we: m1_we, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb, rstrb: m1_rstrb};
  assign sel_in = pick_winner ? m1_in : m0_in;

  ram_arb_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // RAM address/data/strobes come straight from the transaction register, so
  // they hold the last latched payload while the enables are low.
  assign ram_read_addr  = txn.addr;
  assign ram_write_addr = txn.addr;
  assign ram_write_data = txn.wdata;
  assign ram_write_strb = txn.wstrb;
  assign ram_read_strb  = txn.rstrb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ARB_IDLE;
      last_grant       <= 1'b1;
      txn              <= '0;
      ram_write_enable <= 1'b0;
      ram_read_enable  <= 1'b0;
      m0_ack           <= 1'b0;
      m1_ack           <= 1'b0;
      m0_rdata         <= '0;
      m1_rdata         <= '0;
      busy             <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            last_grant       <= pick_winner;
            txn              <= sel_in;
            ram_write_enable <= sel_in.we;
            ram_read_enable  <= ~sel_in.we;
            busy             <= 1'b1;
            state            <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          ram_write_enable <= 1'b0;
          ram_read_enable  <= 1'b0;
          if (last_grant) begin
            m1_ack   <= 1'b1;
            m1_rdata <= txn.we ? '0 : ram_read_data;
          end else begin
            m0_ack   <= 1'b1;
            m0_rdata <= txn.we ? '0 : ram_read_data;
          end
          state <= ARB_RESP;
        end
        ARB_RESP: begin
          m0_ack   <= 1'b0;
          m1_ack   <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
          busy     <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter sharing the single data RAM between the CPU load/store port (master 0) and a second bus master (master 1: boot loader / DMA). Sits between `cpu`/loader and `ram` in `mother_board`, replacing the direct CPU-to-RAM wiring. Each master uses a req/ack handshake. Grants are round-robin, one transaction at a time, with registered RAM drive and a registered read-data return.

## Interface

Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STRB_W`, default 4: byte-strobe width, equal to `DATA_W/8`.

Ports (N = 0, 1):
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mN_req`  in  1  request; held high with stable payload until `mN_ack`.
- `mN_we`  in  1  1 = write, 0 = read.
- `mN_addr`  in  ADDR_W  byte address.
- `mN_wdata`  in  DATA_W  write data.
- `mN_wstrb`  in  STRB_W  write byte strobes.
- `mN_rstrb`  in  STRB_W  read byte strobes.
- `mN_ack`  out  1  one-cycle completion pulse.
- `mN_rdata`  out  DATA_W  read data; valid while `mN_ack` = 1.
- `ram_read_addr`, `ram_write_addr`  out  ADDR_W  to RAM.
- `ram_read_enable`, `ram_write_enable`  out  1  to RAM.
- `ram_write_data`  out  DATA_W  to RAM.
- `ram_write_strb`, `ram_read_strb`  out  STRB_W  to RAM.
- `ram_read_data`  in  DATA_W  from RAM; combinational with respect to the read address.
- `busy`  out  1  high in ACCESS and RESP.

## Operation

- FSM states: `ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`.
- **IDLE, no request:** stay in IDLE.
- **IDLE, request pending:** pick a winner and latch its payload into the transaction register. Record the winner in `last_grant`. Go to ACCESS.
- **Arbitration:**
  - Only one `mN_req` high: that master wins.
  - Both high: the master not equal to `last_grant` wins.
- **ACCESS (exactly 1 cycle):** drive the RAM from the transaction register.
  - Write: `ram_write_enable` = 1 with addr, data and strobes from the register; read enable stays 0.
  - Read: `ram_read_enable` = 1 with addr and rstrb; `ram_read_data` is captured into the `rdata` register at the end of the cycle.
  - Go to RESP.
- **RESP (exactly 1 cycle):** `mN_ack` = 1 for the granted master only. `mN_rdata` shows the captured data; for writes it is 0. Go to IDLE.
- `mN_rdata` of the non-granted master is always 0.
- A payload change after the IDLE sample is ignored.
- A master that drops `mN_req` before ack still completes its transaction, and the ack is still issued.
- Loss of a request mid-transaction is not an error.

## Timing

- **Reset (`reset` = 0):** effective immediately and asynchronously.
  - State goes to IDLE.
  - `last_grant` = 1, so master 0 wins the first tie.
  - All `ack`, RAM enables, RAM address/data/strobe outputs, `rdata` and `busy` go to 0.
  - Reset asserted during ACCESS deasserts `ram_write_enable` at once. The write is either suppressed or completed; it is never duplicated. No ack is issued for the aborted transaction.
- **Latency:** request sampled in IDLE at cycle t, RAM access at t+1, ack at t+2. That is 3 cycles per transaction, or 2 to ack.
- **Back-to-back:** a master that holds `req` high in the cycle after its ack presents a new request, sampled in that IDLE cycle.
- **Throughput:** at most one transaction per 3 cycles.
- **Fairness:** under continuous contention, grants alternate 0,1,0,1. Worst-case wait is one foreign transaction, i.e. ack within 5 cycles of the request.
- **RAM outputs outside ACCESS:** enables are 0; addr, data and strobes hold the last latched values.

## Structure

- Shared package `bus_pkg` holds:
  - `arb_state_t` (enum: `ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`).
  - Width constants `BUS_ADDR_W`, `BUS_DATA_W`, `BUS_STRB_W`.
  - Packed struct `bus_req_t` {we, addr, wdata, wstrb, rstrb}, used for the transaction register and both master inputs.
- One natural sub-module: `ram_arb_pick`, a combinational round-robin picker with inputs (req[1:0], last_grant) and outputs (valid, winner).
- The FSM, transaction register and rdata register live in `ram_arbiter`.

## Test plan

- **Reset values:** hold `reset` = 0 for 3 cycles, then release. All outputs are 0 and `busy` = 0 throughout.
- **Single write then read (master 0):**
  - m0 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF. `ram_write_enable` is high exactly 1 cycle, at t+1; `m0_ack` pulses at t+2.
  - m0 then reads 0x10. `m0_rdata` = 0xDEADBEEF with the ack at t+2; `m1_ack` stays 0 throughout.
- **Tie after reset:** raise `m0_req` and `m1_req` in the same cycle. m0 is acked first (cycle 2), m1 next (cycle 5).
- **Sustained contention:** both masters hold `req` for 12 cycles, re-requesting after each ack. The ack sequence is m0, m1, m0, m1 at cycles 2, 5, 8, 11.
- **Byte strobes:** m1 writes 0x11223344 with wstrb 0x3 to a word preloaded with 0xAABBCCDD. `ram_write_strb` = 0x3 during ACCESS, and a follow-up read returns 0xAABB3344.
- **Reset mid-operation:** assert `reset` during ACCESS of a write. `ram_write_enable` drops asynchronously, and no ack follows. After release, the first request completes normally in 3 cycles.
